// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Bit-serial adder controller. A single full-adder cell adds two WIDTH-bit
//   operands one bit per clock, LSB first. A start request is accepted while
//   the block is not busy (IDLE or DONE). The block then runs WIDTH SHIFT
//   cycles and pulses done for one cycle. The registered sum and cout update
//   on entry to DONE and hold until the next result.
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request pulse, sampled while busy=0
//   a, b   in   WIDTH-bit operands, captured on the accepting edge
//   cin    in   carry-in, captured on the accepting edge
//   busy   out  high during the WIDTH add steps
//   done   out  one-cycle pulse, sum/cout valid
//   sum    out  a+b+cin mod 2^WIDTH, held until the next result
//   cout   out  carry out of bit WIDTH-1, held with sum
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] sa, sb, sr, sr_next;
  logic             c;
  logic [CNT_W-1:0] cnt;
  logic             fa_s, fa_c;
  logic             accept;
  logic             last;

  // The one and only adder in the block: {carry, sum} of three bits.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic z);
    return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
  endfunction

  assign {fa_c, fa_s} = full_add(sa[0], sb[0], c);
  assign last         = (cnt == CNT_W'(WIDTH - 1));
  assign busy         = (state == SHIFT);
  assign done         = (state == DONE);

  // Result register shifts right and the new sum bit enters at the MSB.
  // After WIDTH steps the first (LSB) bit has reached position 0.
  always_comb begin
    sr_next            = sr >> 1;
    sr_next[WIDTH-1]   = fa_s;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        // A request in the done cycle is accepted, giving WIDTH+1 throughput.
        if (start) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      sr    <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        sa  <= a;
        sb  <= b;
        c   <= cin;
        cnt <= '0;
        sr  <= '0;
      end else if (state == SHIFT) begin
        sa  <= sa >> 1;
        sb  <= sb >> 1;
        c   <= fa_c;
        cnt <= cnt + CNT_W'(1);
        sr  <= sr_next;
        // Output registers take the completed result on the last step edge,
        // so they are valid in the same cycle done is high.
        if (last) begin
          sum  <= sr_next;
          cout <= fa_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         cout;

  typedef struct {
    logic [W:0] val;
    int         cyc;
  } exp_t;

  exp_t       q[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  logic [W:0] last_res = '0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Monitor: pops an expected result on every done and checks its timing;
  // while busy, the previous result must be held.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        checks++;
        if (busy) begin
          errors++;
          $display("FAIL done_with_busy: busy=%0b done=%0b, required busy=0", busy, done);
        end
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: got done at cycle %0d sum=%h cout=%0b, required no done",
                   cyc, sum, cout);
        end else begin
          exp_t e;
          e = q.pop_front();
          if ({cout, sum} !== e.val || cyc != e.cyc) begin
            errors++;
            $display("FAIL result: got cout/sum=%h at cycle %0d, required %h at cycle %0d",
                     {cout, sum}, cyc, e.val, e.cyc);
          end
          last_res = e.val;
        end
      end else if (busy) begin
        checks++;
        if ({cout, sum} !== last_res) begin
          errors++;
          $display("FAIL hold: got cout/sum=%h during busy, required %h", {cout, sum}, last_res);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // Issue one request on a non-busy cycle and push its expected result.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic ic, input logic [W:0] exp_val);
    int t;
    exp_t e;
    @(negedge clk);
    t = 0;
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      errors++;
      $display("FAIL busy_timeout: busy still %0b after %0d cycles, required 0", busy, t);
    end
    a     = ia;
    b     = ib;
    cin   = ic;
    start = 1'b1;
    e.val = exp_val;
    e.cyc = cyc + W + 1;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;

    rst_n = 1'b0;
    start = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    #12;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_sum",  64'(sum),  64'd0);
    check("reset_cout", 64'(cout), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic add, with busy checked on the cycle after acceptance.
    issue(8'h5A, 8'h3C, 1'b0, 9'h096);
    check("busy_after_accept", 64'(busy), 64'd1);
    drain();

    // Carry ripple and all-ones.
    issue(8'hFF, 8'h01, 1'b0, 9'h100);
    issue(8'hFF, 8'hFF, 1'b1, 9'h1FF);
    issue(8'h00, 8'h00, 1'b1, 9'h001);
    drain();

    // Ignored start and operand stability while busy.
    issue(8'h10, 8'h20, 1'b0, 9'h030);
    for (int i = 0; i < W; i++) begin
      a     = W'($urandom);
      b     = W'($urandom);
      cin   = 1'($urandom);
      start = (i == 2);
      if (i == 2) begin
        a = 8'hAA;
        b = 8'h55;
      end
      @(negedge clk);
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("no_second_done", 64'(q.size()), 64'd0);

    // Back-to-back with start held high across the done cycle.
    @(negedge clk);
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    q.push_back('{val: 9'h002, cyc: cyc + W + 1});
    repeat (W + 1) @(negedge clk);
    check("b2b_done_cycle", 64'(done), 64'd1);
    a = 8'h80; b = 8'h80; cin = 1'b0;
    q.push_back('{val: 9'h100, cyc: cyc + W + 1});
    @(negedge clk);
    start = 1'b0;
    drain();

    // Reset mid-operation, asserted between clock edges.
    issue(8'h10, 8'h20, 1'b0, 9'h030);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_sum",  64'(sum),  64'd0);
    check("midrst_cout", 64'(cout), 64'd0);
    q.delete();
    last_res = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("midrst_no_done", 64'(q.size()), 64'd0);
    issue(8'h03, 8'h04, 1'b0, 9'h007);
    drain();

    // Random requests, expected from a+b+cin.
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      issue(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc});
    end
    drain();
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
